// File: rtl/gray2bin_rr_sched.sv
// gray2bin_rr_sched
// Two requesters share one bit-serial gray-to-binary converter under round-robin
// arbitration. A word is taken in IDLE, decoded MSB-first one bit per cycle in
// CONV, and held on the output port in HOLD until the consumer accepts it.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req0_valid/gray/ready  requester 0 handshake and gray word
//   req1_valid/gray/ready  requester 1 handshake and gray word
//   out_valid/ready        result handshake
//   out_bin                decoded binary word (meaningful while out_valid)
//   out_id                 requester that owns out_bin
//   busy                   converter is not idle
module gray2bin_rr_sched #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_gray,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_gray,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_id,
  output logic             busy
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StHold
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] acc_q;
  logic [IdxW-1:0]  idx_q;
  logic             prev_q;  // last decoded bit, i.e. acc[idx+1]; 0 above the MSB
  logic             id_q;
  logic             ptr_q;   // 0: req0 wins a tie, 1: req1 wins a tie

  logic             grant0;
  logic             grant1;
  logic             conv_bit;

  // Combinational arbitration, only offered while idle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      grant0 = req0_valid & (~req1_valid | ~ptr_q);
      grant1 = req1_valid & (~req0_valid | ptr_q);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign conv_bit = gray_q[idx_q] ^ prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gray_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      prev_q  <= 1'b0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant0 | grant1) begin
            gray_q  <= grant1 ? req1_gray : req0_gray;
            id_q    <= grant1;
            acc_q   <= '0;
            prev_q  <= 1'b0;
            idx_q   <= IdxW'(WIDTH - 1);
            state_q <= StConv;
          end
        end
        StConv: begin
          acc_q[idx_q] <= conv_bit;
          prev_q       <= conv_bit;
          if (idx_q == '0) begin
            state_q <= StHold;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        StHold: begin
          if (out_ready) begin
            // Hand the tie-break to whoever was not just served.
            ptr_q   <= ~id_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_bin   = acc_q;
  assign out_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_gray2bin_rr_sched.sv
// Self-checking bench for gray2bin_rr_sched: directed sequences, a vector table
// of boundary words and a randomized run, all checked against a transaction
// level model of the scheduler kept in this file.
module tb_gray2bin_rr_sched;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid;
  logic [W-1:0] req0_gray;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_gray;
  logic         req1_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;
  logic         out_id;
  logic         busy;

  gray2bin_rr_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_gray  (req0_gray),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_gray  (req1_gray),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bin    (out_bin),
    .out_id     (out_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Snapshot of DUT outputs taken at the last observation point.
  logic         s_r0, s_r1, s_ov, s_busy, s_id;
  logic [W-1:0] s_bin;

  // Model: a job is either absent, converting with m_left cycles to go, or held.
  logic         m_hold;
  int           m_left;
  logic [W-1:0] m_word;
  logic         m_owner;
  logic         m_pref;

  typedef struct {
    logic [W-1:0] gray;
    logic [W-1:0] bin;
  } vec_t;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < int'(W); s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic m_idle();
    return !m_hold && (m_left == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold  = 1'b0;
    m_left  = 0;
    m_word  = '0;
    m_owner = 1'b0;
    m_pref  = 1'b0;
  endtask

  // Observe just after the falling edge, compare with the model, then step the
  // model across the rising edge.
  task automatic cycle();
    logic e0, e1;
    #1;
    s_r0 = req0_ready; s_r1 = req1_ready; s_ov = out_valid;
    s_busy = busy; s_id = out_id; s_bin = out_bin;
    e0 = m_idle() && req0_valid && (!req1_valid || !m_pref);
    e1 = m_idle() && req1_valid && (!req0_valid || m_pref);
    chk("req0_ready", s_r0, e0);
    chk("req1_ready", s_r1, e1);
    chk("busy", s_busy, !m_idle());
    chk("out_valid", s_ov, m_hold);
    if (m_hold) begin
      chk("out_bin", s_bin, g2b(m_word));
      chk("out_id", s_id, m_owner);
    end
    @(posedge clk);
    if (m_idle()) begin
      if (e0) begin m_word = req0_gray; m_owner = 1'b0; m_left = W; end
      else if (e1) begin m_word = req1_gray; m_owner = 1'b1; m_left = W; end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_hold = 1'b1;
    end else if (out_ready) begin
      m_hold = 1'b0;
      m_pref = ~m_owner;
    end
    @(negedge clk);
  endtask

  // Called on a falling edge; checks that reset clears outputs immediately.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ov(input string name);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!s_ov && n < 50);
    chk(name, s_ov, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[6];
    int           lat, ng, no, cyc, r1_early;
    int           gcyc[4];
    logic         gid[4], oid[4];
    logic [W-1:0] obin[4];
    logic [W-1:0] held_bin;
    logic         held_id;

    tbl[0] = '{gray: 10'b0000000000, bin: 10'b0000000000};
    tbl[1] = '{gray: 10'b0000000001, bin: 10'b0000000001};
    tbl[2] = '{gray: 10'b1100000000, bin: 10'b1000000000};
    tbl[3] = '{gray: 10'b0000001111, bin: 10'b0000001010};
    tbl[4] = '{gray: 10'b1000000000, bin: 10'b1111111111};
    tbl[5] = '{gray: 10'b1111111111, bin: 10'b1010101010};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_gray = '0;
    req1_valid = 1'b0; req1_gray = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // 1: single request, latency and busy span.
    apply_reset();
    req0_valid = 1'b1; req0_gray = 10'b0000001111; out_ready = 1'b1;
    cycle();
    chk("t1_grant", s_r0, 1);
    req0_valid = 1'b0;
    lat = 0;
    do begin
      lat++;
      cycle();
      chk("t1_busy", s_busy, 1);
    end while (!s_ov && lat < 40);
    chk("t1_latency", lat, W + 1);
    chk("t1_bin", s_bin, 10'b0000001010);
    chk("t1_id", s_id, 0);
    cycle();
    chk("t1_idle", s_busy, 0);

    // 2/3: contention, alternation and acceptance spacing.
    apply_reset();
    req0_valid = 1'b1; req0_gray = 10'b0000001111;
    req1_valid = 1'b1; req1_gray = 10'b1000000000;
    out_ready = 1'b1;
    ng = 0; no = 0; cyc = 0; r1_early = 0;
    while ((ng < 4 || no < 4) && cyc < 200) begin
      cycle();
      cyc++;
      if (no == 0 && s_r1) r1_early++;
      if ((s_r0 || s_r1) && ng < 4) begin gid[ng] = s_r1; gcyc[ng] = cyc; ng++; end
      if (s_ov && no < 4) begin oid[no] = s_id; obin[no] = s_bin; no++; end
    end
    chk("t3_grants", ng, 4);
    chk("t3_outputs", no, 4);
    chk("t2_r1_early", r1_early, 0);
    chk("t2_id0", oid[0], 0);
    chk("t2_bin0", obin[0], 10'b0000001010);
    chk("t2_id1", oid[1], 1);
    chk("t2_bin1", obin[1], 10'b1111111111);
    for (int k = 0; k < 4; k++) chk("t3_grant_id", gid[k], k % 2);
    for (int k = 1; k < 4; k++) chk("t3_spacing", gcyc[k] - gcyc[k-1], W + 2);

    // 4: backpressure holds the result; handshake flips priority to req1.
    apply_reset();
    req0_valid = 1'b1; req0_gray = W'($urandom);
    req1_valid = 1'b1; req1_gray = W'($urandom);
    out_ready = 1'b0;
    wait_ov("t4_out_valid");
    held_bin = s_bin; held_id = s_id;
    chk("t4_held_bin", held_bin, g2b(req0_gray));
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_stable_valid", s_ov, 1);
      chk("t4_stable_bin", s_bin, held_bin);
      chk("t4_stable_id", s_id, held_id);
      chk("t4_no_ready", s_r0 | s_r1, 0);
    end
    out_ready = 1'b1;
    cycle();
    chk("t4_handshake", s_ov, 1);
    cycle();
    chk("t4_back_idle_valid", s_ov, 0);
    chk("t4_next_grant_req1", s_r1, 1);

    // 5: reset on the 4th conversion cycle; pointer returns to req0.
    apply_reset();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_gray = W'($urandom); out_ready = 1'b1;
    cycle();
    wait_ov("t5_first_job");
    cycle();
    chk("t5_grant", s_r0, 1);
    for (int k = 0; k < 3; k++) cycle();
    chk("t5_busy_before", busy, 1);
    req1_valid = 1'b1;
    apply_reset();
    cycle();
    chk("t5_ptr_reset_r0", s_r0, 1);
    chk("t5_ptr_reset_r1", s_r1, 0);

    // 6: vector table of boundary and reference words through req1.
    apply_reset();
    req0_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req1_valid = 1'b1; req1_gray = tbl[i].gray;
      cycle();
      chk("t6_grant", s_r1, 1);
      req1_valid = 1'b0;
      wait_ov("t6_out_valid");
      chk("t6_bin", s_bin, tbl[i].bin);
      chk("t6_id", s_id, 1);
    end

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_gray  = W'($urandom);
      req1_gray  = W'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 249) == 0) apply_reset();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray2bin_rr_sched.md
Name: gray2bin_rr_sched

Overview:
Shares one bit-serial gray-to-binary conversion engine between two requesters using round-robin arbitration. Each requester presents a WIDTH-bit gray word with a valid/ready handshake. The block converts the word MSB-first, one bit per cycle, and presents the binary result with the requester ID on a valid/ready output port. It sits in front of downstream logic that consumes decoded counter and position values.

Parameters:
WIDTH, 10, gray/binary word width (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a word
req0_gray  in  WIDTH  requester 0 gray word
req0_ready  out  1  requester 0 word accepted this cycle (when valid)
req1_valid  in  1  requester 1 has a word
req1_gray  in  WIDTH  requester 1 gray word
req1_ready  out  1  requester 1 word accepted this cycle (when valid)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_bin  out  WIDTH  binary result
out_id  out  1  requester that owns out_bin
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; out_bin=0; out_id=0; busy=0.
  - Priority pointer favours req0.
  - Any in-flight word is discarded.
  - Reset takes effect immediately, mid-conversion or mid-HOLD.
- FSM states: IDLE, CONV, HOLD.
- IDLE:
  - Arbitration is combinational.
  - Winner = the only valid requester. If both are valid, winner = the requester the pointer favours.
  - reqN_ready=1 only in IDLE and only for the winner. reqN_ready may depend on reqN_valid.
  - On a valid&ready transfer: latch gray word and ID, clear the accumulator, set bit index to WIDTH-1, go to CONV.
  - With no valid requester, remain in IDLE.
- CONV, WIDTH cycles:
  - Cycle for index i computes acc[i] = gray[i] XOR acc[i+1], with acc[WIDTH-1] = gray[WIDTH-1].
  - After index 0, go to HOLD.
  - Both ready outputs are 0.
- HOLD:
  - out_valid=1; out_bin=acc; out_id=latched ID.
  - All three are stable until out_ready=1.
  - On the out_valid&out_ready cycle: pointer <= favour the other requester (not out_id), go to IDLE.
  - Both ready outputs are 0 throughout HOLD.
- Output timing:
  - out_bin follows the accumulator register at all times, but is only meaningful when out_valid=1.
  - out_id updates on acceptance.
- Latency:
  - Word accepted at edge T. out_valid rises after edge T+WIDTH, i.e. WIDTH+1 cycles after acceptance.
  - Minimum spacing between acceptances is WIDTH+2 cycles (out_ready held high).
- Fairness: with both requesters continuously valid, grants strictly alternate.
- A requester that drops valid before being granted loses nothing; there is no state for it.

Test Plan:
1. Single request, WIDTH=10: reset, then req0_valid=1, req0_gray=10'b0000001111, out_ready=1 -> req0_ready=1 for one cycle; 11 cycles later out_valid=1, out_bin=10'b0000001010, out_id=0; busy=1 from acceptance through the HOLD handshake.
2. Both requesters valid after reset, req0_gray=10'b0000001111, req1_gray=10'b1000000000, both held valid -> first output out_id=0, out_bin=10'b0000001010; second output out_id=1, out_bin=10'b1111111111; req1_ready never high during the first job.
3. Continuous contention, both valid for 4 jobs -> out_id sequence 0,1,0,1; each acceptance spaced 12 cycles apart with out_ready=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid, out_bin and out_id stay stable, both ready outputs stay 0; handshake happens on the cycle out_ready=1, then IDLE.
5. Reset mid-operation: assert rst_n=0 on the 4th CONV cycle -> out_valid=0, out_bin=0, busy=0 immediately. After release with both requesters valid, req0 is granted first.
6. Boundary words: gray 10'b0000000000 -> out_bin 0; gray 10'b0000000001 -> out_bin 10'b0000000001; gray 10'b1100000000 -> out_bin 10'b1000000000.
